weighted_sum_sequencer: RTL
===========================

# weighted_sum_sequencer

- Time-multiplexed controller for the weighted-sum datapath.
- Accepts one vector of `num_inputs` weight/input pairs through a valid/ready handshake.
- Feeds the pairs one per cycle into a single shared registered `multiplier` and accumulates the products.
- Returns the sum through a valid/ready handshake. Used wherever area matters more than throughput, in place of one multiplier per input.

## Interface
Parameters:
- `num_inputs`, 4: elements per vector; must be ≥ 2.
- `bit_length`, 4: width of each weight and each input.

Ports:
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `in_valid` input, 1: `weights`/`inputs` are valid.
- `in_ready` output, 1: block can accept a vector.
- `weights` input, `[num_inputs-1:0][bit_length-1:0]`: weight vector; element i pairs with `inputs[i]`.
- `inputs` input, `[num_inputs-1:0][bit_length-1:0]`: input vector.
- `out_valid` output, 1: `out_sum` holds a completed result.
- `out_ready` input, 1: consumer accepts `out_sum`.
- `out_sum` output, `SUM_W`: accumulated sum, where SUM_W = 2*bit_length + $clog2(num_inputs).
- `busy` output, 1: high in RUN or DRAIN.

## Operation
State machine:
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch both vectors, clear the accumulator, set idx=0, go to RUN.
- RUN:
  - Drive `multiplier` with `weights_q[idx]` and `inputs_q[idx]`.
  - Each cycle, add the product registered on the previous edge to the accumulator; no add occurs on the first RUN cycle.
  - idx increments each cycle. When idx==num_inputs-1, go to DRAIN.
- DRAIN: add the last product and go to DONE.
- DONE:
  - `out_valid`=1; `out_sum` = accumulator, held stable.
  - On `out_valid && out_ready`: go to IDLE.

Arithmetic and handshake rules:
- Products are 2*bit_length wide and are zero-extended to SUM_W before accumulation. SUM_W is sized so the accumulator can never overflow.
- `in_ready`=0 in every state except IDLE. A vector cannot be accepted in the same cycle a result is consumed.
- Latched operands are unaffected by changes on `weights`/`inputs` after acceptance.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.
- Holding `in_valid` or `out_ready` high permanently is legal and gives maximum throughput.

Reset values (during and after `rst`):
- state=IDLE, idx=0, accumulator=0, `out_sum`=0, `out_valid`=0, `busy`=0.
- `in_ready` is forced to 0 while `rst`=1 and goes to 1 on the first cycle after reset.

Reset mid-operation: any in-flight vector or unconsumed result is discarded with no output. The multiplier's pipeline register contents are don't-care after reset, because accumulation restarts only after a new accept.

## Timing
- Edge E0 is the accept edge. At E0+k (1 ≤ k ≤ num_inputs) the product of element k-1 is registered.
- The accumulator includes element k-1 after edge E0+k+1.
- `out_valid` rises after edge E0+num_inputs+1, i.e. latency num_inputs+1 cycles. For num_inputs=4 that is 5 cycles.
- With `out_ready` held at 1, the result is consumed at E0+num_inputs+2 and the next accept is at E0+num_inputs+3. Peak throughput is one vector per num_inputs+3 cycles.
- Backpressure: DONE is held indefinitely with `out_sum` stable.

## Configuration
`WEIGHTED_SUM_SIGNED_EN`:
- Defined: weights and inputs are two's-complement. `multiplier` operands and products are treated as signed, and products are sign-extended to SUM_W.
- Undefined: unsigned operands with zero-extension.
- Latency and handshakes are identical in both builds.

## Structure
- Package `weighted_sum_pkg`:
  - State enum typedef `wss_state_t` (IDLE, RUN, DRAIN, DONE).
  - Function `sum_width(num_inputs, bit_length)` used to define SUM_W.
- One sub-module: the existing `multiplier` (`#(bit_length)`, ports clk, product, a, b; registered output, 1-cycle latency), instantiated exactly once.
- The idx counter, operand mux, accumulator and FSM stay in this module.

## Test plan
Unless stated, num_inputs=4, bit_length=4; vectors are listed as element 0..3.
- Basic: weights {1,2,3,4}, inputs {5,6,7,8}, `out_ready`=1 → `out_valid` exactly 5 cycles after accept with `out_sum`=70, then back in IDLE with `in_ready`=1.
- Max magnitude (unsigned build): all weights and inputs 15 → `out_sum`=900 (10-bit, no overflow).
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_sum` is stable, `in_ready`=0 and new `in_valid` is ignored. When released, the result is consumed and the next vector is accepted 1 cycle later.
- Back-to-back: `in_valid` and `out_ready` tied high with vectors {1,1,1,1}×{1,1,1,1} then {2,0,0,0}×{3,0,0,0} → results 4 then 6, spaced 7 cycles apart.
- Reset mid-RUN: assert `rst` for 1 cycle at E0+2 → no `out_valid`, all outputs at reset values. The next vector {1,2,3,4}×{5,6,7,8} still gives 70.
- Signed build with `WEIGHTED_SUM_SIGNED_EN`: weights all 4'hF (-1), inputs all 7 → `out_sum`=-28, i.e. 10'h3E4.

Source files
------------

// File: rtl/weighted_sum_pkg.sv
// Shared types and sizing helpers for the weighted-sum sequencer.
// Optional build macro: WEIGHTED_SUM_SIGNED_EN (two's-complement operands).
package weighted_sum_pkg;

    // Sequencer phases: wait for a vector, stream pairs, add the last product, present the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wss_state_t;

    // Accumulator width: a full product plus enough headroom for num_inputs additions.
    function automatic int sum_width(input int num_inputs, input int bit_length);
        return 2 * bit_length + $clog2(num_inputs);
    endfunction

endpackage

// File: rtl/weighted_sum_sequencer_multiplier.sv
// Shared registered multiplier: product appears one clock after a/b are presented.
// Optional build macro: WEIGHTED_SUM_SIGNED_EN (operands and product are two's-complement).
module multiplier #(
    parameter int bit_length = 4
) (
    input  logic                      clk,
    output logic [2*bit_length-1:0]   product,
    input  logic [bit_length-1:0]     a,
    input  logic [bit_length-1:0]     b
);

    localparam int PROD_W = 2 * bit_length;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;

`ifdef WEIGHTED_SUM_SIGNED_EN
    // Sign-extend to full product width so the low PROD_W bits of the product are exact.
    assign a_ext = PROD_W'($signed(a));
    assign b_ext = PROD_W'($signed(b));
`else
    assign a_ext = {{bit_length{1'b0}}, a};
    assign b_ext = {{bit_length{1'b0}}, b};
`endif

    // Register the product; the caller accounts for the one-cycle latency.
    // NOTE: this is a pure datapath register with no reset -- its contents are
    // only consumed after a fresh accept, so a reset would add logic for nothing.
    always_ff @(posedge clk) begin
        product <= a_ext * b_ext;
    end

endmodule

// File: rtl/weighted_sum_sequencer.sv
// Time-multiplexed weighted sum: accepts one vector of weight/input pairs, feeds
// them one per cycle through a single registered multiplier and accumulates the
// products, then returns the sum through a valid/ready handshake.
// Optional build macro: WEIGHTED_SUM_SIGNED_EN (signed operands, sign-extended products).
module weighted_sum_sequencer
    import weighted_sum_pkg::*;
#(
    parameter int num_inputs = 4,
    parameter int bit_length = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [num_inputs-1:0][bit_length-1:0]         weights,
    input  logic [num_inputs-1:0][bit_length-1:0]         inputs,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [sum_width(num_inputs, bit_length)-1:0]  out_sum,
    output logic                                          busy
);

    localparam int SUM_W  = sum_width(num_inputs, bit_length);
    localparam int PROD_W = 2 * bit_length;
    localparam int IDX_W  = $clog2(num_inputs);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_inputs - 1);

    wss_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [num_inputs-1:0][bit_length-1:0] weights_q;
    logic [num_inputs-1:0][bit_length-1:0] inputs_q;
    logic load_en;

    logic [PROD_W-1:0] product;
    logic [SUM_W-1:0]  product_ext;

    multiplier #(
        .bit_length(bit_length)
    ) u_multiplier (
        .clk    (clk),
        .product(product),
        .a      (weights_q[idx_q]),
        .b      (inputs_q[idx_q])
    );

`ifdef WEIGHTED_SUM_SIGNED_EN
    assign product_ext = SUM_W'($signed(product));
`else
    assign product_ext = SUM_W'(product);
`endif

    // Next-state logic: walk idx across the vector, adding the product registered one edge earlier.
    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        load_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_en = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // On the first RUN cycle the multiplier still holds a stale product.
                if (idx_q != '0) begin
                    acc_d = acc_q + product_ext;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                acc_d   = acc_q + product_ext;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and accumulator state, cleared by synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    // Operand capture on accept; held until the next accept so input changes cannot disturb a run.
    always_ff @(posedge clk) begin
        if (load_en) begin
            weights_q <= weights;
            inputs_q  <= inputs;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign out_sum   = acc_q;

endmodule
